// File: rtl/kernel_mem_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module   : kernel_mem_burst_responder
//  Purpose  : Avalon-MM burst responder for kernel global-memory masters.
//             Accepts kernel read/write bursts (up to BURSTCOUNT_MAX words)
//             and re-issues them as registered single-word AVMM commands.
//             Read data comes back in order with one cycle of latency.
//             Outstanding read words are limited by a credit counter.
//  Ports    : clk, reset_n (synchronous, active-low)
//             s_*  : kernel-side burst slave (address, read, write, burstcount,
//                    writedata, byteenable, waitrequest, readdata,
//                    readdatavalid)
//             m_*  : memory-side single-word master (address, read, write,
//                    writedata, byteenable, waitrequest, readdata,
//                    readdatavalid)
//             rd_outstanding : read words issued and not yet returned
//             bad_burst      : sticky flag for an illegal burstcount
//  Revision : 1.0  initial release
// ============================================================================
module kernel_mem_burst_responder #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 512,
   parameter int BYTE_OFFSET        = 6,
   parameter int BURSTCOUNT_WIDTH   = 5,
   parameter int BURSTCOUNT_MAX     = 16,
   parameter int MAX_OUTSTANDING_RD = 64
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [ADDR_WIDTH-1:0]                  s_address,
   input  logic                                   s_read,
   input  logic                                   s_write,
   input  logic [BURSTCOUNT_WIDTH-1:0]            s_burstcount,
   input  logic [DATA_WIDTH-1:0]                  s_writedata,
   input  logic [DATA_WIDTH/8-1:0]                s_byteenable,
   output logic                                   s_waitrequest,
   output logic [DATA_WIDTH-1:0]                  s_readdata,
   output logic                                   s_readdatavalid,
   output logic [ADDR_WIDTH-1:0]                  m_address,
   output logic                                   m_read,
   output logic                                   m_write,
   output logic [DATA_WIDTH-1:0]                  m_writedata,
   output logic [DATA_WIDTH/8-1:0]                m_byteenable,
   input  logic                                   m_waitrequest,
   input  logic [DATA_WIDTH-1:0]                  m_readdata,
   input  logic                                   m_readdatavalid,
   output logic [$clog2(MAX_OUTSTANDING_RD+1)-1:0] rd_outstanding,
   output logic                                   bad_burst
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING_RD + 1);
   // Common width wide enough for credit compares and the outstanding sum
   localparam int CMP_W = ((OUT_W > BURSTCOUNT_WIDTH) ? OUT_W : BURSTCOUNT_WIDTH) + 1;
   localparam logic [ADDR_WIDTH-1:0]       ADDR_INC  = ADDR_WIDTH'(1) << BYTE_OFFSET;
   localparam logic [BURSTCOUNT_WIDTH-1:0] BURST_MAX = BURSTCOUNT_WIDTH'(BURSTCOUNT_MAX);
   localparam logic [BURSTCOUNT_WIDTH-1:0] BURST_ONE = BURSTCOUNT_WIDTH'(1);
   localparam logic [OUT_W-1:0]            CREDITS_TOTAL = OUT_W'(MAX_OUTSTANDING_RD);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_BURST = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [BURSTCOUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic                        m_read_q, m_read_d;
   logic                        m_write_q, m_write_d;
   logic [ADDR_WIDTH-1:0]       m_address_q, m_address_d;
   logic [DATA_WIDTH-1:0]       m_writedata_q, m_writedata_d;
   logic [DATA_WIDTH/8-1:0]     m_byteenable_q, m_byteenable_d;
   logic [DATA_WIDTH-1:0]       s_readdata_q, s_readdata_d;
   logic                        s_readdatavalid_q, s_readdatavalid_d;
   logic [OUT_W-1:0]            rd_outstanding_q, rd_outstanding_d;
   logic                        bad_burst_q, bad_burst_d;

   logic                        cmd_free;
   logic [BURSTCOUNT_WIDTH-1:0] eff_len;
   logic                        burst_bad;
   logic [OUT_W-1:0]            credits;
   logic                        credit_ok;
   logic [ADDR_WIDTH-1:0]       base_addr;
   logic [BURSTCOUNT_WIDTH-1:0] rd_issue_len;
   logic [CMP_W-1:0]            rd_sum;
   logic                        s_waitrequest_c;

   // Sub-word address bits are intentionally discarded (word-aligned issue)
   logic unused_addr_bits;
   assign unused_addr_bits = ^s_address[BYTE_OFFSET-1:0];

   // The command register may be reloaded when empty or when its current
   // command is being taken downstream this cycle.
   assign cmd_free  = !(m_read_q || m_write_q) || !m_waitrequest;
   assign base_addr = {s_address[ADDR_WIDTH-1:BYTE_OFFSET], {BYTE_OFFSET{1'b0}}};
   assign credits   = CREDITS_TOTAL - rd_outstanding_q;
   assign credit_ok = CMP_W'(credits) >= CMP_W'(eff_len);

   // Clamp illegal burst lengths to a legal value and flag them
   always_comb begin
      eff_len   = s_burstcount;
      burst_bad = 1'b0;
      if (s_burstcount == '0) begin
         eff_len   = BURST_ONE;
         burst_bad = 1'b1;
      end else if (s_burstcount > BURST_MAX) begin
         eff_len   = BURST_MAX;
         burst_bad = 1'b1;
      end
   end

   // Next-state and command generation
   always_comb begin
      state_d         = state_q;
      remaining_d     = remaining_q;
      addr_d          = addr_q;
      m_read_d        = m_read_q;
      m_write_d       = m_write_q;
      m_address_d     = m_address_q;
      m_writedata_d   = m_writedata_q;
      m_byteenable_d  = m_byteenable_q;
      bad_burst_d     = bad_burst_q;
      rd_issue_len    = '0;
      s_waitrequest_c = 1'b1;

      // A free command slot with nothing new to issue goes idle
      if (cmd_free) begin
         m_read_d  = 1'b0;
         m_write_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // Read has priority over a simultaneous write
            if (s_read) begin
               if (cmd_free && credit_ok) begin
                  s_waitrequest_c = 1'b0;
                  m_read_d        = 1'b1;
                  m_address_d     = base_addr;
                  addr_d          = base_addr + ADDR_INC;
                  rd_issue_len    = eff_len;
                  bad_burst_d     = bad_burst_q | burst_bad;
                  remaining_d     = eff_len - BURST_ONE;
                  if (eff_len != BURST_ONE) begin
                     state_d = ST_RD_BURST;
                  end
               end
            end else if (s_write) begin
               if (cmd_free) begin
                  s_waitrequest_c = 1'b0;
                  m_write_d       = 1'b1;
                  m_address_d     = base_addr;
                  m_writedata_d   = s_writedata;
                  m_byteenable_d  = s_byteenable;
                  addr_d          = base_addr + ADDR_INC;
                  bad_burst_d     = bad_burst_q | burst_bad;
                  remaining_d     = eff_len - BURST_ONE;
                  if (eff_len != BURST_ONE) begin
                     state_d = ST_WR_BURST;
                  end
               end
            end
         end

         ST_RD_BURST: begin
            // Credits for the whole burst were taken at accept time
            if (cmd_free) begin
               m_read_d    = 1'b1;
               m_address_d = addr_q;
               addr_d      = addr_q + ADDR_INC;
               remaining_d = remaining_q - BURST_ONE;
               if (remaining_q == BURST_ONE) begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_WR_BURST: begin
            s_waitrequest_c = !cmd_free;
            if (cmd_free && s_write) begin
               m_write_d      = 1'b1;
               m_address_d    = addr_q;
               m_writedata_d  = s_writedata;
               m_byteenable_d = s_byteenable;
               addr_d         = addr_q + ADDR_INC;
               remaining_d    = remaining_q - BURST_ONE;
               if (remaining_q == BURST_ONE) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read response path and credit accounting. A return with no read
   // outstanding (e.g. a pre-reset read arriving late) is absorbed at zero.
   always_comb begin
      s_readdata_d      = m_readdata;
      s_readdatavalid_d = m_readdatavalid;
      rd_sum            = CMP_W'(rd_outstanding_q) + CMP_W'(rd_issue_len);
      if (s_readdatavalid_q) begin
         rd_sum = (rd_sum == '0) ? '0 : rd_sum - CMP_W'(1);
      end
      rd_outstanding_d = OUT_W'(rd_sum);
   end

   // Control state, reset synchronously
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q           <= ST_IDLE;
         m_read_q          <= 1'b0;
         m_write_q         <= 1'b0;
         s_readdatavalid_q <= 1'b0;
         rd_outstanding_q  <= '0;
         bad_burst_q       <= 1'b0;
         remaining_q       <= '0;
      end else begin
         state_q           <= state_d;
         m_read_q          <= m_read_d;
         m_write_q         <= m_write_d;
         s_readdatavalid_q <= s_readdatavalid_d;
         rd_outstanding_q  <= rd_outstanding_d;
         bad_burst_q       <= bad_burst_d;
         remaining_q       <= remaining_d;
      end
   end

   // Datapath registers; qualified by the control flops above
   always_ff @(posedge clk) begin
      addr_q         <= addr_d;
      m_address_q    <= m_address_d;
      m_writedata_q  <= m_writedata_d;
      m_byteenable_q <= m_byteenable_d;
      s_readdata_q   <= s_readdata_d;
   end

   assign s_waitrequest   = s_waitrequest_c;
   assign s_readdata      = s_readdata_q;
   assign s_readdatavalid = s_readdatavalid_q;
   assign m_address       = m_address_q;
   assign m_read          = m_read_q;
   assign m_write         = m_write_q;
   assign m_writedata     = m_writedata_q;
   assign m_byteenable    = m_byteenable_q;
   assign rd_outstanding  = rd_outstanding_q;
   assign bad_burst       = bad_burst_q;

endmodule
`default_nettype wire

// File: tb/tb_kernel_mem_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kernel_mem_burst_responder
//  Purpose  : Self-checking bench for kernel_mem_burst_responder with a
//             credit limit of 16 read words and a simple in-order memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kernel_mem_burst_responder;

   localparam int AW    = 32;
   localparam int DW    = 512;
   localparam int BW    = 5;
   localparam int MAXRD = 16;
   localparam int OW    = $clog2(MAXRD + 1);

   logic            clk = 1'b0;
   logic            reset_n;
   logic [AW-1:0]   s_address;
   logic            s_read, s_write;
   logic [BW-1:0]   s_burstcount;
   logic [DW-1:0]   s_writedata;
   logic [DW/8-1:0] s_byteenable;
   logic            s_waitrequest;
   logic [DW-1:0]   s_readdata;
   logic            s_readdatavalid;
   logic [AW-1:0]   m_address;
   logic            m_read, m_write;
   logic [DW-1:0]   m_writedata;
   logic [DW/8-1:0] m_byteenable;
   logic            m_waitrequest;
   logic [DW-1:0]   m_readdata;
   logic            m_readdatavalid;
   logic [OW-1:0]   rd_outstanding;
   logic            bad_burst;

   kernel_mem_burst_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_OFFSET(6), .BURSTCOUNT_WIDTH(BW),
      .BURSTCOUNT_MAX(16), .MAX_OUTSTANDING_RD(MAXRD)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_burstcount(s_burstcount), .s_writedata(s_writedata),
      .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid),
      .rd_outstanding(rd_outstanding), .bad_burst(bad_burst)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              wr;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [DW/8-1:0] be;
   } cmd_t;

   typedef struct {
      bit            rd;
      logic [AW-1:0] addr;
      logic [BW-1:0] bc;
      int            exp_beats;
      bit            exp_bad;
   } vec_t;

   cmd_t          exp_cmd[$];
   logic [DW-1:0] exp_rd[$];
   logic [AW-1:0] resp_q[$];
   bit            resp_en;
   int            n_checks = 0;
   int            n_errors = 0;
   int            n_cmds   = 0;
   int            n_rets   = 0;
   bit            prev_mrv = 1'b0;
   cmd_t          mon_e;
   logic [DW-1:0] mon_d;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic int eff(input logic [BW-1:0] bc);
      if (bc == 0) return 1;
      if (bc > 16) return 16;
      return int'(bc);
   endfunction

   function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int k);
      return (a & ~32'h3F) + 32'(k) * 32'd64;
   endfunction

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      logic [DW-1:0] d;
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = a ^ (32'(j) * 32'h0100_0193);
      return d;
   endfunction

   function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a, input int k);
      logic [DW-1:0] d;
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = (a ^ (32'(k + 1) * 32'h9E37_79B9)) + 32'(j);
      return d;
   endfunction

   function automatic logic [DW/8-1:0] wbe(input int k);
      logic [63:0] b;
      b = 64'hF0F0_1234_5678_ABCD;
      return b ^ (64'(k + 1) << (k * 3));
   endfunction

   // Wait (bounded) for the cycle in which the DUT accepts the driven request
   task automatic wait_accept(output int out_at_acc);
      int t;
      bit done;
      t = 0; done = 1'b0; out_at_acc = -1;
      while (!done) begin
         @(negedge clk);
         if (!s_waitrequest) begin
            out_at_acc = int'(rd_outstanding);
            done = 1'b1;
         end else begin
            t++;
            if (t > 300) begin
               n_checks++; n_errors++;
               $display("FAIL accept_timeout: got waitrequest=1 for %0d cycles, required accept", t);
               done = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; s_read = 1'b0; s_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      resp_q.delete(); exp_cmd.delete(); exp_rd.delete();
   endtask

   task automatic read_burst(input logic [AW-1:0] a, input logic [BW-1:0] bc, output int acc);
      cmd_t e;
      for (int k = 0; k < eff(bc); k++) begin
         e.wr = 1'b0; e.addr = beat_addr(a, k); e.data = '0; e.be = '0;
         exp_cmd.push_back(e);
         exp_rd.push_back(mem_word(e.addr));
      end
      s_read = 1'b1; s_address = a; s_burstcount = bc;
      wait_accept(acc);
      s_read = 1'b0;
   endtask

   task automatic write_beat(input logic [AW-1:0] a, input logic [BW-1:0] bc, input int k);
      cmd_t e;
      int acc;
      e.wr = 1'b1; e.addr = beat_addr(a, k); e.data = wdata(a, k); e.be = wbe(k);
      exp_cmd.push_back(e);
      s_write = 1'b1; s_address = a; s_burstcount = bc;
      s_writedata = e.data; s_byteenable = e.be;
      wait_accept(acc);
      s_write = 1'b0;
   endtask

   task automatic write_burst(input logic [AW-1:0] a, input logic [BW-1:0] bc, input int gap_after);
      for (int k = 0; k < eff(bc); k++) begin
         write_beat(a, bc, k);
         if (k == gap_after) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_cmd.size() != 0 || exp_rd.size() != 0 || resp_q.size() != 0 || s_readdatavalid)
             && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         n_checks++; n_errors++;
         $display("FAIL drain_timeout: got %0d cmds / %0d reads pending, required 0",
                  exp_cmd.size(), exp_rd.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------ memory responder
   initial begin
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
      forever begin
         @(posedge clk); #1;
         if (resp_en && resp_q.size() > 0) begin
            m_readdata      = mem_word(resp_q.pop_front());
            m_readdatavalid = 1'b1;
         end else begin
            m_readdatavalid = 1'b0;
         end
      end
   end

   // ------------------------------------------------------ scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_mrv = 1'b0;
         end else begin
            if ((m_read || m_write) && !m_waitrequest) begin
               n_cmds++;
               if (exp_cmd.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL cmd_unexpected: got wr=%0b addr=%h, required no command", m_write, m_address);
               end else begin
                  mon_e = exp_cmd.pop_front();
                  check("cmd_kind", 64'({m_read, m_write}), 64'({!mon_e.wr, mon_e.wr}));
                  check("cmd_addr", 64'(m_address), 64'(mon_e.addr));
                  if (mon_e.wr) begin
                     check_wide("wr_data", m_writedata, mon_e.data);
                     check("wr_be", m_byteenable, mon_e.be);
                  end else begin
                     resp_q.push_back(m_address);
                  end
               end
            end
            if (s_readdatavalid) begin
               n_rets++;
               if (exp_rd.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL rdata_unexpected: got %h, required no data", s_readdata[31:0]);
               end else begin
                  mon_d = exp_rd.pop_front();
                  check_wide("rdata", s_readdata, mon_d);
               end
            end
            if (s_readdatavalid || prev_mrv)
               check("rdv_latency", 64'(s_readdatavalid), 64'(prev_mrv));
            prev_mrv = m_readdatavalid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1);
   end

   // ------------------------------------------------------------ main test
   vec_t vecs[9];
   int   acc;
   logic [AW-1:0] stall_addr;
   bit   stable;

   initial begin
      vecs[0] = '{1'b1, 32'h0000_1040, 5'd4,  4,  1'b0};
      vecs[1] = '{1'b1, 32'h0000_0000, 5'd0,  1,  1'b1};
      vecs[2] = '{1'b1, 32'h0000_0100, 5'd31, 16, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_0007, 5'd1,  1,  1'b0};
      vecs[4] = '{1'b1, 32'hFFFF_FF80, 5'd3,  3,  1'b0};
      vecs[5] = '{1'b0, 32'h0000_3000, 5'd3,  3,  1'b0};
      vecs[6] = '{1'b0, 32'hFFFF_FFC5, 5'd2,  2,  1'b0};
      vecs[7] = '{1'b0, 32'h0000_0040, 5'd0,  1,  1'b1};
      vecs[8] = '{1'b0, 32'h0000_0080, 5'd17, 16, 1'b1};

      s_read = 1'b0; s_write = 1'b0; s_address = '0; s_burstcount = '0;
      s_writedata = '0; s_byteenable = '0; m_waitrequest = 1'b0;
      resp_en = 1'b1; reset_n = 1'b0;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_m_read", 64'(m_read), 64'd0);
      check("rst_m_write", 64'(m_write), 64'd0);
      check("rst_s_rdv", 64'(s_readdatavalid), 64'd0);
      check("rst_rd_out", 64'(rd_outstanding), 64'd0);
      check("rst_bad", 64'(bad_burst), 64'd0);
      @(posedge clk); #1;

      // Read burst 4 at 0x1040, no stalls
      n_cmds = 0; n_rets = 0;
      read_burst(32'h0000_1040, 5'd4, acc);
      check("rd4_outstanding_after_accept", 64'(rd_outstanding), 64'd4);
      drain();
      check("rd4_beats", 64'(n_cmds), 64'd4);
      check("rd4_returns", 64'(n_rets), 64'd4);
      check("rd4_outstanding_end", 64'(rd_outstanding), 64'd0);

      // Table of single bursts
      for (int i = 0; i < 9; i++) begin
         do_reset();
         n_cmds = 0;
         if (vecs[i].rd) read_burst(vecs[i].addr, vecs[i].bc, acc);
         else            write_burst(vecs[i].addr, vecs[i].bc, -1);
         drain();
         check($sformatf("vec%0d_beats", i), 64'(n_cmds), 64'(vecs[i].exp_beats));
         check($sformatf("vec%0d_bad", i), 64'(bad_burst), 64'(vecs[i].exp_bad));
         check($sformatf("vec%0d_rd_out", i), 64'(rd_outstanding), 64'd0);
      end

      // Credit limit: 16 in flight blocks a 2-word burst until 2 return
      do_reset();
      resp_en = 1'b0;
      read_burst(32'h0000_0000, 5'd16, acc);
      for (int k = 0; k < 2; k++) begin
         cmd_t e;
         e.wr = 1'b0; e.addr = beat_addr(32'h0000_8000, k); e.data = '0; e.be = '0;
         exp_cmd.push_back(e);
         exp_rd.push_back(mem_word(e.addr));
      end
      s_read = 1'b1; s_address = 32'h0000_8000; s_burstcount = 5'd2;
      repeat (24) @(posedge clk);
      @(negedge clk);
      check("credit_hold_wait", 64'(s_waitrequest), 64'd1);
      check("credit_hold_rd_out", 64'(rd_outstanding), 64'd16);
      @(posedge clk); #1;
      resp_en = 1'b1;
      wait_accept(acc);
      s_read = 1'b0;
      check("credit_accept_at", 64'(acc), 64'd14);
      check("credit_same_cycle_net", 64'(rd_outstanding), 64'd15);
      drain();
      check("credit_rd_out_end", 64'(rd_outstanding), 64'd0);

      // Write burst 3 with a one-cycle gap after the first beat
      do_reset();
      n_cmds = 0;
      write_burst(32'h0000_3000, 5'd3, 0);
      drain();
      check("wr_gap_beats", 64'(n_cmds), 64'd3);

      // Downstream stall of 5 cycles in the middle of a read burst
      do_reset();
      n_cmds = 0;
      read_burst(32'h0000_2000, 5'd8, acc);
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_waitrequest = 1'b1;
      @(negedge clk);
      stall_addr = m_address;
      check("stall_m_read", 64'(m_read), 64'd1);
      stable = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (m_address !== stall_addr || m_read !== 1'b1) stable = 1'b0;
      end
      @(posedge clk); #1;
      m_waitrequest = 1'b0;
      check("stall_stable", 64'(stable), 64'd1);
      drain();
      check("stall_beats", 64'(n_cmds), 64'd8);

      // Sticky bad_burst until reset
      do_reset();
      read_burst(32'h0000_0000, 5'd0, acc);
      drain();
      read_burst(32'h0000_0400, 5'd2, acc);
      drain();
      check("bad_sticky", 64'(bad_burst), 64'd1);
      do_reset();
      @(negedge clk);
      check("bad_cleared", 64'(bad_burst), 64'd0);
      @(posedge clk); #1;

      // Reset pulse during beat 2 of an 8-beat write
      do_reset();
      write_beat(32'h0000_5000, 5'd8, 0);
      write_beat(32'h0000_5000, 5'd8, 1);
      s_write = 1'b1; s_writedata = wdata(32'h0000_5000, 2); s_byteenable = wbe(2);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1; s_write = 1'b0;
      exp_cmd.delete();
      @(negedge clk);
      check("midrst_m_write", 64'(m_write), 64'd0);
      check("midrst_m_read", 64'(m_read), 64'd0);
      check("midrst_rd_out", 64'(rd_outstanding), 64'd0);
      check("midrst_bad", 64'(bad_burst), 64'd0);
      @(posedge clk); #1;
      n_cmds = 0;
      write_burst(32'h0000_6000, 5'd2, -1);
      drain();
      check("midrst_new_beats", 64'(n_cmds), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
